vx_tcu_fedp_ctrl: RTL and testbench

//  Issue/retire controller on the initiator side of the TCU fused dot-product (FEDP) datapath.

---
 rtl/vx_tcu_fedp_ctrl_pkg.sv | 24 ++
 rtl/vx_tcu_fedp_tracker.sv | 55 +++++
 rtl/vx_tcu_fedp_ctrl.sv | 91 +++++++++
 tb/tb_vx_tcu_fedp_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_tcu_fedp_ctrl_pkg.sv
// Shared TCU definitions: operand format encodings and FEDP pipeline latency.
package vx_tcu_fedp_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] FMT_FP16 = 3'd1;
  localparam logic [2:0] FMT_BF16 = 3'd2;
  localparam logic [2:0] FMT_TF32 = 3'd3;

  localparam int unsigned FMUL_LAT = 2;
  localparam int unsigned FADD_LAT = 2;
  localparam int unsigned FRND_LAT = 1;

  // Multiply, widen, adder tree over 2N lanes, final accumulate + round.
  function automatic int unsigned fedp_latency(input int unsigned n);
    return (FMUL_LAT + 1) + 1 + $clog2(2 * n) * (FADD_LAT + 1) + (FADD_LAT + FRND_LAT);
  endfunction

  // Source formats the FEDP does not understand; the result is flagged, not dropped.
  function automatic logic fmt_illegal(input logic [2:0] fmt);
    return !(fmt inside {FMT_FP16, FMT_BF16, FMT_TF32});
  endfunction

endpackage

// File: rtl/vx_tcu_fedp_tracker.sv
// In-flight tracker running in lockstep with the FEDP pipeline.
module vx_tcu_fedp_tracker #(
  parameter int unsigned LATENCY = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_err,
  input  logic             retire,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] inflight
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] err_q;
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic [CNT_W-1:0]   inflight_q;

  // Valid/err shift only with the FEDP; count tracks accepts minus retires.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q    <= '0;
      err_q      <= '0;
      inflight_q <= '0;
    end else begin
      if (enable) begin
        valid_q <= {valid_q[LATENCY-2:0], in_valid};
        err_q   <= {err_q[LATENCY-2:0], in_err};
      end
      inflight_q <= inflight_q + CNT_W'(in_valid) - CNT_W'(retire);
    end
  end

  // Tags need no reset: they are only looked at under a valid bit.
  always_ff @(posedge clk) begin
    if (enable) begin
      tag_q[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];
  assign inflight  = inflight_q;

endmodule

// File: rtl/vx_tcu_fedp_ctrl.sv
// Issue/retire controller for the TCU fused dot-product datapath.
module vx_tcu_fedp_ctrl
  import vx_tcu_fedp_ctrl_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned LATENCY = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_fmt_s,
  input  logic [2:0]          req_fmt_d,
  input  logic [N*XLEN-1:0]   req_a_row,
  input  logic [N*XLEN-1:0]   req_b_col,
  input  logic [XLEN-1:0]     req_c_val,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                fedp_enable,
  output logic                fedp_reset,
  output logic [2:0]          fedp_fmt_s,
  output logic [2:0]          fedp_fmt_d,
  output logic [N*XLEN-1:0]   fedp_a_row,
  output logic [N*XLEN-1:0]   fedp_b_col,
  output logic [XLEN-1:0]     fedp_c_val,
  input  logic [XLEN-1:0]     fedp_d_val,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_d_val,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                rsp_err,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  // Tracker depth must match the attached FEDP or tags and results drift apart.
  if (LATENCY != fedp_latency(N)) begin : g_bad_latency
    $error("vx_tcu_fedp_ctrl: LATENCY does not match fedp_latency(N)");
  end

  logic             stall;
  logic             accept;
  logic             retire;
  logic [CNT_W-1:0] inflight;

  // Head blocked by the consumer freezes the whole pipe; idle pipe also freezes.
  assign stall       = rsp_valid && !rsp_ready;
  assign req_ready   = !stall;
  assign accept      = req_valid && req_ready;
  assign retire      = rsp_valid && rsp_ready;
  assign fedp_enable = !stall && (req_valid || (inflight != '0));
  assign fedp_reset  = !reset;
  assign rsp_d_val   = fedp_d_val;
  assign busy        = inflight != '0;

  // Operand mux: real request on accept, otherwise a zero fp16 bubble.
  always_comb begin
    fedp_fmt_s = FMT_FP16;
    fedp_fmt_d = '0;
    fedp_a_row = '0;
    fedp_b_col = '0;
    fedp_c_val = '0;
    if (accept) begin
      fedp_fmt_s = req_fmt_s;
      fedp_fmt_d = req_fmt_d;
      fedp_a_row = req_a_row;
      fedp_b_col = req_b_col;
      fedp_c_val = req_c_val;
    end
  end

  vx_tcu_fedp_tracker #(
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W),
    .CNT_W   (CNT_W)
  ) u_trk (
    .clk       (clk),
    .reset     (reset),
    .enable    (fedp_enable),
    .in_valid  (accept),
    .in_tag    (req_tag),
    .in_err    (accept && fmt_illegal(req_fmt_s)),
    .retire    (retire),
    .out_valid (rsp_valid),
    .out_tag   (rsp_tag),
    .out_err   (rsp_err),
    .inflight  (inflight)
  );

endmodule

// File: tb/tb_vx_tcu_fedp_ctrl.sv
// Bench for vx_tcu_fedp_ctrl with a stand-in FEDP and a queue-based reference.
module tb_vx_tcu_fedp_ctrl;

  localparam int L = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_fmt_s;
  logic [2:0]   req_fmt_d;
  logic [127:0] req_a_row;
  logic [127:0] req_b_col;
  logic [31:0]  req_c_val;
  logic [7:0]   req_tag;
  logic         fedp_enable;
  logic         fedp_reset;
  logic [2:0]   fedp_fmt_s;
  logic [2:0]   fedp_fmt_d;
  logic [127:0] fedp_a_row;
  logic [127:0] fedp_b_col;
  logic [31:0]  fedp_c_val;
  logic [31:0]  fedp_d_val;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_d_val;
  logic [7:0]   rsp_tag;
  logic         rsp_err;
  logic         busy;

  always #5 clk = ~clk;

  vx_tcu_fedp_ctrl #(.N(4), .TAG_W(8), .LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt_s(req_fmt_s), .req_fmt_d(req_fmt_d),
    .req_a_row(req_a_row), .req_b_col(req_b_col),
    .req_c_val(req_c_val), .req_tag(req_tag),
    .fedp_enable(fedp_enable), .fedp_reset(fedp_reset),
    .fedp_fmt_s(fedp_fmt_s), .fedp_fmt_d(fedp_fmt_d),
    .fedp_a_row(fedp_a_row), .fedp_b_col(fedp_b_col),
    .fedp_c_val(fedp_c_val), .fedp_d_val(fedp_d_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_d_val(rsp_d_val), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err), .busy(busy)
  );

  wire [4:0] inflight_obs = dut.inflight;

  // Golden FEDP result: exact for the all-ones fp16 case, a mixing hash otherwise.
  function automatic logic [31:0] golden(input logic [2:0] fs, input logic [127:0] a,
                                         input logic [127:0] b, input logic [31:0] c);
    logic [127:0] ones;
    logic [31:0]  h, aw, bw;
    ones = {8{16'h3C00}};
    if (fs == 3'd1 && a == ones && b == ones && c == 32'h3F800000) return 32'h41100000;
    h = c ^ {29'd0, fs};
    for (int i = 0; i < 4; i++) begin
      aw = a[i*32 +: 32];
      bw = b[i*32 +: 32];
      h  = {h[26:0], h[31:27]} ^ aw ^ {bw[15:0], bw[31:16]};
    end
    return h;
  endfunction

  // Stand-in FEDP: L-stage enable-gated pipe computing golden() on its pins.
  logic [31:0] fpipe [L];
  always @(posedge clk) begin
    if (fedp_enable) begin
      fpipe[0] <= golden(fedp_fmt_s, fedp_a_row, fedp_b_col, fedp_c_val);
      for (int i = 1; i < L; i++) fpipe[i] <= fpipe[i-1];
    end
  end
  assign fedp_d_val = fpipe[L-1];

  typedef struct {
    logic [7:0]  tag;
    logic        err;
    logic [31:0] d;
    int          stamp;
  } item_t;

  item_t q[$];
  int    adv_cnt = 0;
  int    checks = 0;
  int    errors = 0;
  bit    chk_on = 0;
  int    cyc = 0;
  int    run = 0, max_run = 0, peak = 0, rv_seen = 0;
  int    last_acc_cyc = 0, last_rsp_cyc = 0;
  logic [31:0] last_rsp_d;
  logic [7:0]  last_rsp_tag;
  logic        err_seen [256];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check at negedge against the model, then advance the model at posedge.
  task automatic cycle();
    logic  rv, st, ac, en;
    item_t it;
    @(negedge clk);
    cyc++;
    rv = (q.size() != 0) && (adv_cnt - q[0].stamp == L - 1);
    st = rv && !rsp_ready;
    ac = req_valid && !st;
    en = !st && (req_valid || q.size() != 0);
    it.tag   = req_tag;
    it.err   = !(req_fmt_s inside {3'd1, 3'd2, 3'd3});
    it.d     = golden(req_fmt_s, req_a_row, req_b_col, req_c_val);
    it.stamp = 0;
    if (chk_on) begin
      chk("rsp_valid", rsp_valid, rv);
      chk("req_ready", req_ready, !st);
      chk("fedp_enable", fedp_enable, en);
      chk("busy", busy, q.size() != 0);
      chk("inflight", inflight_obs, q.size());
      chk("fedp_reset", fedp_reset, !reset);
      if (rv) begin
        chk("rsp_tag", rsp_tag, q[0].tag);
        chk("rsp_err", rsp_err, q[0].err);
        if (!q[0].err) chk("rsp_d_val", rsp_d_val, q[0].d);
      end
      if (ac) begin
        chk("fedp_a_row", fedp_a_row, req_a_row);
        chk("fedp_b_col", fedp_b_col, req_b_col);
        chk("fedp_c_val", fedp_c_val, req_c_val);
        chk("fedp_fmt_s", fedp_fmt_s, req_fmt_s);
        chk("fedp_fmt_d", fedp_fmt_d, req_fmt_d);
      end else if (en) begin
        chk("bubble_a", fedp_a_row, 128'd0);
        chk("bubble_c", fedp_c_val, 128'd0);
        chk("bubble_fmt", fedp_fmt_s, 128'd1);
      end
    end
    if (rsp_valid === 1'b1 && rsp_ready) begin
      run++;
      if (run > max_run) max_run = run;
      last_rsp_cyc = cyc;
      last_rsp_d   = rsp_d_val;
      last_rsp_tag = rsp_tag;
      err_seen[rsp_tag] = rsp_err;
    end else begin
      run = 0;
    end
    if (rsp_valid === 1'b1) rv_seen++;
    if (int'(inflight_obs) > peak) peak = int'(inflight_obs);
    if (ac) last_acc_cyc = cyc;
    @(posedge clk);
    if (!reset) begin
      q.delete();
    end else begin
      if (rv && rsp_ready) void'(q.pop_front());
      if (en) adv_cnt++;
      if (ac) begin
        it.stamp = adv_cnt;
        q.push_back(it);
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] fs, input logic [7:0] tag,
                       input logic [127:0] a, input logic [127:0] b, input logic [31:0] c);
    req_valid = v;
    req_fmt_s = fs;
    req_fmt_d = 3'($urandom_range(0, 3));
    req_tag   = tag;
    req_a_row = a;
    req_b_col = b;
    req_c_val = c;
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (q.size() == 0) break;
      cycle();
    end
    chk("drain_busy", busy, 1'b0);
  endtask

  initial begin
    logic [127:0] ones;
    ones = {8{16'h3C00}};
    reset = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b0, 3'd1, 8'd0, '0, '0, '0);
    cycle();
    chk_on = 1;
    cycle();
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    reset = 1'b1;
    cycle();

    // 1: single fp16 request, exact latency and value
    drive(1'b1, 3'd1, 8'd5, ones, ones, 32'h3F800000);
    cycle();
    req_valid = 1'b0;
    drain();
    chk("t1_latency", 128'(last_rsp_cyc - last_acc_cyc), 128'd16);
    chk("t1_d_val", last_rsp_d, 32'h41100000);
    chk("t1_tag", last_rsp_tag, 8'd5);

    // 2: 32 back-to-back requests
    max_run = 0;
    peak = 0;
    for (int t = 0; t < 32; t++) begin
      drive(1'b1, 3'd1, 8'(t), r128(), r128(), $urandom);
      cycle();
    end
    req_valid = 1'b0;
    drain();
    chk("t2_run", 128'(max_run), 128'd32);
    chk("t2_peak", 128'(peak), 128'd16);

    // 3: consumer stall with 16 in flight
    max_run = 0;
    for (int t = 0; t < 16; t++) begin
      drive(1'b1, 3'd2, 8'(100 + t), r128(), r128(), $urandom);
      cycle();
    end
    drive(1'b1, 3'd2, 8'hAA, r128(), r128(), $urandom);
    rsp_ready = 1'b0;
    repeat (10) cycle();
    chk("t3_rsp_valid", rsp_valid, 1'b1);
    chk("t3_req_ready", req_ready, 1'b0);
    chk("t3_enable", fedp_enable, 1'b0);
    chk("t3_head_tag", rsp_tag, 8'd100);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    chk("t3_drain_run", 128'(max_run), 128'd16);

    // 4: steady accept+retire with random bf16/tf32
    for (int t = 0; t < 116; t++) begin
      drive(1'b1, ($urandom_range(0, 1) != 0) ? 3'd2 : 3'd3, 8'(t), r128(), r128(), $urandom);
      cycle();
      if (t >= 16) chk("t4_inflight", inflight_obs, 5'd16);
    end
    req_valid = 1'b0;
    drain();

    // 5: illegal fmt between legal neighbours
    for (int i = 0; i < 256; i++) err_seen[i] = 1'bx;
    drive(1'b1, 3'd1, 8'd8, r128(), r128(), $urandom);
    cycle();
    drive(1'b1, 3'd0, 8'd9, r128(), r128(), $urandom);
    cycle();
    drive(1'b1, 3'd3, 8'd10, r128(), r128(), $urandom);
    cycle();
    req_valid = 1'b0;
    drain();
    chk("t5_err8", err_seen[8], 1'b0);
    chk("t5_err9", err_seen[9], 1'b1);
    chk("t5_err10", err_seen[10], 1'b0);

    // 6: reset with 8 in flight drops them silently
    for (int t = 0; t < 8; t++) begin
      drive(1'b1, 3'd1, 8'(200 + t), r128(), r128(), $urandom);
      cycle();
    end
    req_valid = 1'b0;
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    rv_seen = 0;
    repeat (24) cycle();
    chk("t6_no_rsp", 128'(rv_seen), 128'd0);
    chk("t6_busy_idle", busy, 1'b0);
    drive(1'b1, 3'd2, 8'h77, r128(), r128(), $urandom);
    cycle();
    req_valid = 1'b0;
    chk("t6_busy_one", busy, 1'b1);
    drain();
    chk("t6_latency", 128'(last_rsp_cyc - last_acc_cyc), 128'd16);
    chk("t6_tag", last_rsp_tag, 8'h77);

    // Random traffic and backpressure
    for (int t = 0; t < 400; t++) begin
      drive(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 4)), 8'($urandom),
            r128(), r128(), $urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
